// File: rtl/apb_master_arb.sv
// Round-robin APB master: NREQ requesters share one APB slave, IDLE->SETUP->ACCESS per transfer.
// Write rsp 3 cycles after accept (+RD_LAT for reads); requesters stall via req_ready, slave via pready/timeout.
module apb_master_arb #(
    parameter int NREQ    = 2,
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RD_LAST = 8'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RDWAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, owner_q, gnt_idx, idx;
    logic            gnt_any;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q, rdata_q;
    logic            err_q;
    logic [7:0]      cnt_q;

    // Search starts one past the last winner so a just-served requester goes last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (gnt_any) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    if (write_q || RD_LAT == 0) state_d = S_RESP;
                    else                        state_d = S_RDWAIT;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RDWAIT: if (cnt_q == RD_LAST) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && gnt_any) begin
                ptr_q   <= gnt_idx;
                owner_q <= gnt_idx;
                write_q <= req_write[gnt_idx];
                addr_q  <= req_addr[gnt_idx*AW +: AW];
                wdata_q <= req_wdata[gnt_idx*DW +: DW];
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            // Counter restarts on every state change, so it times both ACCESS and RDWAIT.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_ACCESS || state_q == S_RDWAIT)
                cnt_q <= cnt_q + 8'd1;
            if (state_q == S_ACCESS) begin
                if (pready) begin
                    if (!write_q && RD_LAT == 0) rdata_q <= prdata;
                end else if (cnt_q == TO_LAST) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == S_RDWAIT && cnt_q == RD_LAST)
                rdata_q <= prdata;
        end
    end

    always_comb begin
        psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable   = (state_q == S_ACCESS);
        pwrite    = write_q;
        paddr     = addr_q;
        pwdata    = wdata_q;
        rsp_valid = '0;
        req_ready = '0;
        rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
        rsp_err   = (state_q == S_RESP) && err_q;
        if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
        // Gated by reset so no handshake can appear while held in reset.
        if (state_q == S_IDLE && gnt_any && preset) req_ready[gnt_idx] = 1'b1;
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a small APB slave model per instance.
module tb_apb_master_arb;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata, prdata;
    logic        pready;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb_master_arb #(.NREQ(2), .AW(4), .DW(8), .RD_LAT(1), .TIMEOUT(15)) dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    // Slave for the main instance: read data valid only in the cycle before the capture edge.
    logic [7:0] mem [16] = '{default: 8'h00};
    int rd_cnt = 0;
    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
        if (rd_cnt != 0) rd_cnt <= 0;
        if (psel && penable && pready && !pwrite) rd_cnt <= 1;
    end
    assign prdata = (rd_cnt == 1) ? mem[paddr] : 8'hEE;

    // Two extra instances for read-latency variants, sharing one request stream.
    logic [1:0] v5;
    logic [1:0] rr0, rv0, rr2, rv2;
    logic [7:0] rd0, rd2, pd0, pd2, prd0, prd2;
    logic       re0, ps0, pe0, pw0, re2, ps2, pe2, pw2;
    logic [3:0] pa0, pa2;
    int rd_cnt2 = 0;

    apb_master_arb #(.NREQ(2), .AW(4), .DW(8), .RD_LAT(0), .TIMEOUT(15)) dut_l0 (
        .pclk(pclk), .preset(preset), .req_valid(v5), .req_write(2'b00),
        .req_addr(8'h22), .req_wdata(16'h0000), .req_ready(rr0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0),
        .psel(ps0), .penable(pe0), .pwrite(pw0), .paddr(pa0),
        .pwdata(pd0), .prdata(prd0), .pready(1'b1)
    );
    assign prd0 = (ps0 && pe0 && pa0 == 4'h2) ? 8'hA5 : 8'hEE;

    apb_master_arb #(.NREQ(2), .AW(4), .DW(8), .RD_LAT(2), .TIMEOUT(15)) dut_l2 (
        .pclk(pclk), .preset(preset), .req_valid(v5), .req_write(2'b00),
        .req_addr(8'h22), .req_wdata(16'h0000), .req_ready(rr2),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2),
        .psel(ps2), .penable(pe2), .pwrite(pw2), .paddr(pa2),
        .pwdata(pd2), .prdata(prd2), .pready(1'b1)
    );
    always @(posedge pclk) begin
        if (rd_cnt2 == 1)      rd_cnt2 <= 2;
        else if (rd_cnt2 == 2) rd_cnt2 <= 0;
        if (ps2 && pe2 && !pw2) rd_cnt2 <= 1;
    end
    assign prd2 = (rd_cnt2 == 2 && pa2 == 4'h2) ? 8'hA5 : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        #1;
        while (!req_ready[i] && n < 20) begin
            @(negedge pclk); #1;
            n++;
        end
        chk("wait_ready", 32'(req_ready[i]), 32'd1);
    endtask

    task automatic do_xfer(input int i, input logic w, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output int acc, output logic [1:0] rv,
                           output logic [7:0] rd, output logic er, output logic ps);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*4 +: 4]  = a;
        req_wdata[i*8 +: 8] = d;
        wait_ready(i);
        @(posedge pclk); #1;
        req_valid[i] = 1'b0;
        lat = 0;
        acc = 0;
        while (lat < 40) begin
            @(negedge pclk);
            lat++;
            if (lat == 1) begin
                chk("setup_phase", {psel, penable}, 2'b10);
                chk("setup_addr", paddr, a);
                chk("setup_write", pwrite, w);
            end
            acc += int'(psel && penable);
            if (rsp_valid != 2'b00) break;
        end
        rv = rsp_valid;
        rd = rsp_rdata;
        er = rsp_err;
        ps = psel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, acc, g, nr, cyc, bad, got, lat0, lat2;
        logic [1:0] rv, last_g, seen;
        logic [1:0] exp_g [4];
        logic [7:0] rd, d0, d2;
        logic er, ps;

        preset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b1; v5 = '0;
        repeat (2) @(negedge pclk);
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_paddr", paddr, 4'h0);
        req_valid = 2'b00;
        preset = 1'b1;

        // Both requesters held: strict alternation starting at req0.
        @(negedge pclk);
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        req_valid = 2'b11; req_write = 2'b11; req_addr = 8'h21; req_wdata = 16'h2211;
        g = 0; nr = 0; cyc = 0; last_g = 2'b00;
        #1;
        while (nr < 4 && cyc < 80) begin
            if (rsp_valid != 2'b00) begin
                chk("t2_rsp_owner", rsp_valid, last_g);
                nr++;
            end
            if (req_ready != 2'b00 && g < 4) begin
                chk("t2_grant", req_ready, exp_g[g]);
                last_g = req_ready;
                g++;
                if (g == 4) begin
                    @(posedge pclk); #1;
                    req_valid = 2'b00;
                end
            end
            @(negedge pclk); #1;
            cyc++;
        end
        chk("t2_nrsp", nr, 4);
        chk("t2_mem1", mem[1], 8'h11);
        chk("t2_mem2", mem[2], 8'h22);

        // Write then read back through req0.
        @(negedge pclk);
        do_xfer(0, 1'b1, 4'hF, 8'h01, lat, acc, rv, rd, er, ps);
        chk("t1_wr_lat", lat, 3);
        chk("t1_wr_owner", rv, 2'b01);
        chk("t1_wr_err", er, 1'b0);
        chk("t1_wr_rdata", rd, 8'h00);
        chk("t1_mem", mem[15], 8'h01);
        do_xfer(0, 1'b0, 4'hF, 8'h00, lat, acc, rv, rd, er, ps);
        chk("t1_rd_lat", lat, 4);
        chk("t1_rd_owner", rv, 2'b01);
        chk("t1_rd_rdata", rd, 8'h01);
        chk("t1_rd_err", er, 1'b0);

        // Slave never ready: abort after TIMEOUT ACCESS cycles.
        pready = 1'b0;
        do_xfer(0, 1'b0, 4'h3, 8'h00, lat, acc, rv, rd, er, ps);
        chk("t3_access_cycles", acc, 15);
        chk("t3_lat", lat, 17);
        chk("t3_psel", ps, 1'b0);
        chk("t3_owner", rv, 2'b01);
        chk("t3_err", er, 1'b1);
        chk("t3_rdata", rd, 8'h00);
        pready = 1'b1;

        // req1 appears and withdraws while req0 is on the bus.
        req_write = 2'b11; req_addr = 8'hC5; req_wdata = 16'h7755;
        req_valid = 2'b01;
        wait_ready(0);
        @(posedge pclk); #1;
        req_valid = 2'b10;
        @(negedge pclk); #1;
        chk("t6_no_ready_busy", req_ready, 2'b00);
        @(negedge pclk);
        req_valid = 2'b00;
        bad = 0; got = 0;
        repeat (10) begin
            @(negedge pclk); #1;
            if (rsp_valid == 2'b10 || req_ready[1] || paddr == 4'hC || pwdata == 8'h77) bad++;
            if (rsp_valid == 2'b01) got++;
        end
        chk("t6_req1_leak", bad, 0);
        chk("t6_req0_rsp", got, 1);
        chk("t6_mem5", mem[5], 8'h55);
        chk("t6_memC", mem[12], 8'h00);

        // Reset during ACCESS of a write that the slave never completes.
        @(negedge pclk);
        pready = 1'b0;
        req_write = 2'b01; req_addr = 8'h09; req_wdata = 16'h0099;
        req_valid = 2'b01;
        wait_ready(0);
        @(posedge pclk); #1;
        req_valid = 2'b00;
        @(negedge pclk);
        @(negedge pclk); #1;
        chk("t4_in_access", penable, 1'b1);
        preset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t4_psel", psel, 1'b0);
        chk("t4_penable", penable, 1'b0);
        chk("t4_rsp_valid", rsp_valid, 2'b00);
        chk("t4_req_ready", req_ready, 2'b00);
        seen = 2'b00;
        repeat (3) begin
            @(negedge pclk); #1;
            seen |= rsp_valid;
        end
        preset = 1'b1;
        pready = 1'b1;
        #1;
        chk("t4_first_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        repeat (4) begin
            @(negedge pclk); #1;
            seen |= rsp_valid;
        end
        chk("t4_no_rsp", seen, 2'b00);
        chk("t4_mem9", mem[9], 8'h00);

        // Read-latency variants on the same preloaded location.
        @(negedge pclk);
        v5 = 2'b01;
        #1;
        chk("t5_ready_l0", rr0, 2'b01);
        chk("t5_ready_l2", rr2, 2'b01);
        @(posedge pclk); #1;
        v5 = 2'b00;
        lat0 = 0; lat2 = 0; cyc = 0; d0 = 8'h00; d2 = 8'h00;
        while (cyc < 12 && (lat0 == 0 || lat2 == 0)) begin
            @(negedge pclk);
            cyc++;
            if (rv0 != 2'b00 && lat0 == 0) begin lat0 = cyc; d0 = rd0; end
            if (rv2 != 2'b00 && lat2 == 0) begin lat2 = cyc; d2 = rd2; end
        end
        chk("t5_lat_rdlat0", lat0, 3);
        chk("t5_lat_rdlat2", lat2, 5);
        chk("t5_rdata_rdlat0", d0, 8'hA5);
        chk("t5_rdata_rdlat2", d2, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
